// File: rtl/heart_sprite_render.sv
// ---------------------------------------------------------------------------
// heart_sprite_render
//
// Draws the player heart sprite inside the battle box and owns the heart's
// position and invulnerability state.
//
// Position moves one pixel per frame tick in the requested direction and is
// clamped so the whole sprite stays inside the box.  A 3-stage pixel pipeline
// turns the current (i_x, i_y) into a ROM address and then into a drawn
// pixel:
//   stage 1: region test + ROM address (registered)
//   stage 2: in-region flag delayed to line up with the ROM read data
//   stage 3: transparency / blink gating, colour output (registered)
// While invulnerable the heart blinks in 4-frame phases.
//
// Ports
//   i_clk2        : pixel clock, all state on rising edge
//   i_rst         : asynchronous active-high reset
//   i_x, i_y      : current pixel column / row
//   i_video_on    : active-video flag
//   i_frame_tick  : one-cycle pulse per frame (vertical blanking)
//   i_up/down/left/right : level-sensitive movement requests
//   i_hit         : one-cycle damage pulse
//   o_rom_addr    : sprite ROM address (0..224)
//   i_rom_data    : sprite ROM pixel, valid one cycle after o_rom_addr
//   o_heart_on    : heart pixel to be drawn
//   o_rgb         : heart pixel colour (0 when not drawn)
//   o_heart_x/y   : current top-left heart position
//   o_invuln      : heart is invulnerable
// ---------------------------------------------------------------------------
module heart_sprite_render #(
    parameter int           HEART_W       = 15,
    parameter int           HEART_H       = 15,
    parameter int           BOX_X0        = 220,
    parameter int           BOX_X1        = 420,
    parameter int           BOX_Y0        = 240,
    parameter int           BOX_Y1        = 400,
    parameter int           START_X       = 313,
    parameter int           START_Y       = 313,
    parameter logic [7:0]   TRANSPARENT   = 8'h00,
    parameter int           INVULN_FRAMES = 60
) (
    input  logic        i_clk2,
    input  logic        i_rst,
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    input  logic        i_video_on,
    input  logic        i_frame_tick,
    input  logic        i_up,
    input  logic        i_down,
    input  logic        i_left,
    input  logic        i_right,
    input  logic        i_hit,
    output logic [9:0]  o_rom_addr,
    input  logic [7:0]  i_rom_data,
    output logic        o_heart_on,
    output logic [7:0]  o_rgb,
    output logic [9:0]  o_heart_x,
    output logic [9:0]  o_heart_y,
    output logic        o_invuln
);

    localparam logic [10:0] X_MIN   = 11'(BOX_X0);
    localparam logic [10:0] X_MAX   = 11'(BOX_X1 - HEART_W + 1);
    localparam logic [10:0] Y_MIN   = 11'(BOX_Y0);
    localparam logic [10:0] Y_MAX   = 11'(BOX_Y1 - HEART_H + 1);
    localparam logic [9:0]  X_START = 10'(START_X);
    localparam logic [9:0]  Y_START = 10'(START_Y);
    localparam logic [6:0]  INV_LD  = 7'(INVULN_FRAMES);

    // Clamp an 11-bit candidate position into [lo, hi].
    function automatic logic [9:0] clamp_pos(input logic [10:0] v,
                                             input logic [10:0] lo,
                                             input logic [10:0] hi);
        logic [10:0] r;
        r = v;
        if (v < lo) r = lo;
        if (v > hi) r = hi;
        return r[9:0];
    endfunction

    logic [9:0]  r_hx;
    logic [9:0]  r_hy;
    logic [6:0]  r_cnt;

    logic [10:0] w_hx_req;
    logic [10:0] w_hy_req;
    logic [9:0]  w_hx_nxt;
    logic [9:0]  w_hy_nxt;

    // Opposing requests cancel because both terms are applied together.
    assign w_hx_req = {1'b0, r_hx} + {10'd0, i_right} - {10'd0, i_left};
    assign w_hy_req = {1'b0, r_hy} + {10'd0, i_down}  - {10'd0, i_up};
    assign w_hx_nxt = clamp_pos(w_hx_req, X_MIN, X_MAX);
    assign w_hy_nxt = clamp_pos(w_hy_req, Y_MIN, Y_MAX);

    always_ff @(posedge i_clk2 or posedge i_rst) begin
        if (i_rst) begin
            r_hx <= X_START;
            r_hy <= Y_START;
        end else if (i_frame_tick) begin
            r_hx <= w_hx_nxt;
            r_hy <= w_hy_nxt;
        end
    end

    // A hit only (re)arms the counter from zero, so a hit that coincides
    // with a frame tick loads the full length without decrementing.
    always_ff @(posedge i_clk2 or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 7'd0;
        end else if (i_hit && (r_cnt == 7'd0)) begin
            r_cnt <= INV_LD;
        end else if (i_frame_tick && (r_cnt != 7'd0)) begin
            r_cnt <= r_cnt - 7'd1;
        end
    end

    logic w_visible;
    assign w_visible = (r_cnt == 7'd0) ? 1'b1 : r_cnt[2];

    // ---- stage 1: region test and ROM address ----
    logic [10:0] w_x11;
    logic [10:0] w_y11;
    logic [10:0] w_hx11;
    logic [10:0] w_hy11;
    logic        w_region;
    logic [9:0]  w_dx;
    logic [9:0]  w_dy;
    logic [9:0]  w_addr;

    // 11-bit compare keeps hx+HEART_W from wrapping near the 10-bit limit.
    assign w_x11    = {1'b0, i_x};
    assign w_y11    = {1'b0, i_y};
    assign w_hx11   = {1'b0, r_hx};
    assign w_hy11   = {1'b0, r_hy};
    assign w_region = i_video_on
                   && (w_x11 >= w_hx11) && (w_x11 < w_hx11 + 11'(HEART_W))
                   && (w_y11 >= w_hy11) && (w_y11 < w_hy11 + 11'(HEART_H));
    assign w_dx     = i_x - r_hx;
    assign w_dy     = i_y - r_hy;
    assign w_addr   = w_dy * 10'(HEART_W) + w_dx;

    logic [9:0] r_rom_addr_p1;
    logic       r_region_p1;

    always_ff @(posedge i_clk2 or posedge i_rst) begin
        if (i_rst) begin
            r_rom_addr_p1 <= 10'd0;
            r_region_p1   <= 1'b0;
        end else begin
            r_rom_addr_p1 <= w_region ? w_addr : 10'd0;
            r_region_p1   <= w_region;
        end
    end

    // ---- stage 2: align region flag with ROM read data ----
    logic r_region_p2;

    always_ff @(posedge i_clk2 or posedge i_rst) begin
        if (i_rst) begin
            r_region_p2 <= 1'b0;
        end else begin
            r_region_p2 <= r_region_p1;
        end
    end

    // ---- stage 3: transparency and blink gating ----
    logic       w_draw;
    logic       r_heart_on_p3;
    logic [7:0] r_rgb_p3;

    assign w_draw = r_region_p2 && (i_rom_data != TRANSPARENT) && w_visible;

    always_ff @(posedge i_clk2 or posedge i_rst) begin
        if (i_rst) begin
            r_heart_on_p3 <= 1'b0;
            r_rgb_p3      <= 8'h00;
        end else begin
            r_heart_on_p3 <= w_draw;
            r_rgb_p3      <= w_draw ? i_rom_data : 8'h00;
        end
    end

    assign o_rom_addr = r_rom_addr_p1;
    assign o_heart_on = r_heart_on_p3;
    assign o_rgb      = r_rgb_p3;
    assign o_heart_x  = r_hx;
    assign o_heart_y  = r_hy;
    assign o_invuln   = (r_cnt != 7'd0);

endmodule

// File: tb/tb_heart_sprite_render.sv
module tb_heart_sprite_render;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] i_x, i_y;
    logic       i_video_on, i_frame_tick;
    logic       i_up, i_down, i_left, i_right, i_hit;
    logic [9:0] o_rom_addr;
    logic [7:0] rom_q;
    logic       o_heart_on;
    logic [7:0] o_rgb;
    logic [9:0] o_heart_x, o_heart_y;
    logic       o_invuln;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    heart_sprite_render dut (
        .i_clk2      (clk),
        .i_rst       (rst),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_video_on  (i_video_on),
        .i_frame_tick(i_frame_tick),
        .i_up        (i_up),
        .i_down      (i_down),
        .i_left      (i_left),
        .i_right     (i_right),
        .i_hit       (i_hit),
        .o_rom_addr  (o_rom_addr),
        .i_rom_data  (rom_q),
        .o_heart_on  (o_heart_on),
        .o_rgb       (o_rgb),
        .o_heart_x   (o_heart_x),
        .o_heart_y   (o_heart_y),
        .o_invuln    (o_invuln)
    );

    // Sprite ROM stand-in: address 0 is E0, address 5 is transparent,
    // everything else is {addr[6:0],1}.
    function automatic logic [7:0] rom_fn(input logic [9:0] a);
        if (a == 10'd0) return 8'hE0;
        if (a == 10'd5) return 8'h00;
        return {a[6:0], 1'b1};
    endfunction

    always @(posedge clk) rom_q <= rom_fn(o_rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            i_frame_tick = 1'b1;
            step();
            i_frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic vo, input logic [9:0] exp_addr,
                       input logic exp_on, input logic [7:0] exp_rgb);
        i_x = x; i_y = y; i_video_on = vo;
        step();
        chk({tag, "_addr"}, o_rom_addr, exp_addr);
        i_video_on = 1'b0; i_x = 10'd0; i_y = 10'd0;
        step();
        step();
        chk({tag, "_on"}, o_heart_on, exp_on);
        chk({tag, "_rgb"}, o_rgb, exp_rgb);
    endtask

    initial begin
        rst = 1'b1;
        i_x = 0; i_y = 0; i_video_on = 0; i_frame_tick = 0;
        i_up = 0; i_down = 0; i_left = 0; i_right = 0; i_hit = 0;
        step(); step(); step();
        chk("rst_addr", o_rom_addr, 10'd0);
        chk("rst_on", o_heart_on, 1'b0);
        chk("rst_rgb", o_rgb, 8'h00);
        chk("rst_x", o_heart_x, 10'd313);
        chk("rst_y", o_heart_y, 10'd313);
        chk("rst_inv", o_invuln, 1'b0);
        rst = 1'b0;
        step();

        // pixel pipeline, heart at (313,313)
        pix("p_origin", 10'd313, 10'd313, 1'b1, 10'd0,   1'b1, 8'hE0);
        pix("p_corner", 10'd327, 10'd327, 1'b1, 10'd224, 1'b1, 8'hC1);
        pix("p_right1", 10'd328, 10'd327, 1'b1, 10'd0,   1'b0, 8'h00);
        pix("p_vidoff", 10'd327, 10'd313, 1'b0, 10'd0,   1'b0, 8'h00);
        pix("p_left1",  10'd312, 10'd313, 1'b1, 10'd0,   1'b0, 8'h00);
        pix("p_above",  10'd313, 10'd312, 1'b1, 10'd0,   1'b0, 8'h00);
        pix("p_transp", 10'd318, 10'd313, 1'b1, 10'd5,   1'b0, 8'h00);
        pix("p_inner",  10'd314, 10'd314, 1'b1, 10'd16,  1'b1, 8'h21);

        // movement and clamping
        i_right = 1'b1;
        tick(200);
        chk("mv_right_clamp", o_heart_x, 10'd406);
        tick(5);
        chk("mv_right_hold", o_heart_x, 10'd406);
        i_right = 1'b0;
        i_up = 1'b1;
        tick(100);
        chk("mv_up_clamp", o_heart_y, 10'd240);
        i_up = 1'b0;
        i_left = 1'b1; i_right = 1'b1;
        tick(10);
        chk("mv_lr_cancel", o_heart_x, 10'd406);
        i_right = 1'b0;
        tick(6);
        chk("mv_left6", o_heart_x, 10'd400);
        i_left = 1'b0;
        i_down = 1'b1;
        tick(60);
        chk("mv_down60", o_heart_y, 10'd300);
        i_down = 1'b0;
        i_right = 1'b1;
        step(); step();
        chk("mv_no_tick", o_heart_x, 10'd400);
        i_right = 1'b0;

        // invulnerability and blink, heart at (400,300)
        chk("inv_idle", o_invuln, 1'b0);
        i_hit = 1'b1; step(); i_hit = 1'b0;
        chk("inv_hit1", o_invuln, 1'b1);
        pix("blink_cnt60", 10'd400, 10'd300, 1'b1, 10'd0, 1'b1, 8'hE0);
        tick(4);
        pix("blink_cnt56", 10'd400, 10'd300, 1'b1, 10'd0, 1'b0, 8'h00);
        tick(6);
        i_hit = 1'b1; step(); i_hit = 1'b0;
        chk("inv_hit2", o_invuln, 1'b1);
        tick(49);
        chk("inv_59ticks", o_invuln, 1'b1);
        tick(1);
        chk("inv_60ticks", o_invuln, 1'b0);
        pix("blink_done", 10'd400, 10'd300, 1'b1, 10'd0, 1'b1, 8'hE0);

        // hit coinciding with a frame tick loads full length
        i_hit = 1'b1; i_frame_tick = 1'b1; step();
        i_hit = 1'b0; i_frame_tick = 1'b0; step();
        tick(59);
        chk("coinc_59", o_invuln, 1'b1);
        tick(1);
        chk("coinc_60", o_invuln, 1'b0);

        // mid-frame reset with pipeline full and heart invulnerable
        i_hit = 1'b1; step(); i_hit = 1'b0;
        chk("pre_rst_inv", o_invuln, 1'b1);
        i_x = 10'd400; i_y = 10'd300; i_video_on = 1'b1;
        step(); step(); step();
        chk("pre_rst_on", o_heart_on, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_on", o_heart_on, 1'b0);
        chk("arst_rgb", o_rgb, 8'h00);
        chk("arst_addr", o_rom_addr, 10'd0);
        chk("arst_x", o_heart_x, 10'd313);
        chk("arst_y", o_heart_y, 10'd313);
        chk("arst_inv", o_invuln, 1'b0);
        i_video_on = 1'b0;
        step();
        rst = 1'b0;
        step(); step(); step();
        chk("post_rst_on", o_heart_on, 1'b0);
        pix("post_rst_pix", 10'd313, 10'd313, 1'b1, 10'd0, 1'b1, 8'hE0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/heart_sprite_render.md
HEART_SPRITE_RENDER -- requirements
Module: heart_sprite_render

Interface
REQ-001 Parameter HEART_W, 15: sprite width in pixels.
REQ-002 Parameter HEART_H, 15: sprite height in pixels.
REQ-003 Parameters BOX_X0/BOX_X1, 220/420: inclusive horizontal bounds of the battle box.
REQ-004 Parameters BOX_Y0/BOX_Y1, 240/400: inclusive vertical bounds of the battle box.
REQ-005 Parameters START_X/START_Y, 313/313: top-left heart position after reset.
REQ-006 Parameter TRANSPARENT, 8'h00: ROM pixel value treated as see-through.
REQ-007 Parameter INVULN_FRAMES, 60: invulnerability length in frames.
REQ-008 The block SHALL use one clock, i_clk2 (in, 1): all state is clocked on its rising edge.
REQ-009 The block SHALL use i_rst (in, 1): reset, asynchronous, active-high.
REQ-010 The block SHALL provide these ports: i_x (in, 10): current pixel column; i_y (in, 10): current pixel row; i_video_on (in, 1): active-video flag.
REQ-011 The block SHALL provide i_frame_tick (in, 1): one-cycle pulse per frame, asserted in vertical blanking.
REQ-012 The block SHALL provide i_up, i_down, i_left, i_right (in, 1 each): level-sensitive movement requests.
REQ-013 The block SHALL provide i_hit (in, 1): one-cycle damage pulse.
REQ-014 The block SHALL provide o_rom_addr (out, 10): address to the 225-entry heart sprite ROM.
REQ-015 The block SHALL provide i_rom_data (in, 8): ROM pixel, valid one cycle after o_rom_addr.
REQ-016 The block SHALL provide o_heart_on (out, 1): heart pixel to be drawn; o_rgb (out, 8): pixel colour.
REQ-017 The block SHALL provide o_heart_x, o_heart_y (out, 10 each): current top-left position; o_invuln (out, 1): invulnerable.

Function
REQ-018 Position (hx, hy) SHALL update only on cycles with i_frame_tick=1: hx += i_right - i_left; hy += i_down - i_up.
REQ-019 Opposing requests held together SHALL give zero movement on that axis.
REQ-020 Position SHALL clamp to hx in [BOX_X0, BOX_X1-HEART_W+1] and hy in [BOX_Y0, BOX_Y1-HEART_H+1]; a request past a bound holds the position at the bound.
REQ-021 Region test SHALL be i_video_on && hx<=i_x<hx+HEART_W && hy<=i_y<hy+HEART_H.
REQ-022 The region test SHALL use 11-bit arithmetic so that no wrap-around occurs.
REQ-023 Stage 1 (registered): o_rom_addr = (i_y-hy)*HEART_W + (i_x-hx) when inside the region, giving 0..224.
REQ-024 Stage 1: o_rom_addr = 0 when outside the region; the in-region flag is registered alongside it.
REQ-025 Stage 2: the in-region flag SHALL be delayed one cycle to align with i_rom_data.
REQ-026 Stage 3 (registered): o_heart_on = region_d2 && i_rom_data != TRANSPARENT && visible.
REQ-027 Stage 3: o_rgb = i_rom_data when o_heart_on is set, else 8'h00.
REQ-028 Total latency from i_x/i_y/i_video_on to o_heart_on/o_rgb SHALL be 3 cycles, with one new pixel accepted every cycle.
REQ-029 Invulnerability counter (7 bits): on i_hit with count 0, load INVULN_FRAMES.
REQ-030 The invulnerability counter SHALL ignore i_hit while the count is nonzero.
REQ-031 The invulnerability counter SHALL decrement on i_frame_tick while nonzero.
REQ-032 If i_hit and i_frame_tick coincide with count 0, the counter SHALL load INVULN_FRAMES with no decrement that cycle.
REQ-033 o_invuln SHALL equal (count != 0).
REQ-034 visible SHALL be 1 when count == 0, else count[2], so the heart blinks in 4-frame phases.
REQ-035 Position, counter and pipeline SHALL update independently in the same cycle without interaction.

Reset
REQ-036 While i_rst=1, asynchronously: hx=START_X, hy=START_Y, counter=0, o_invuln=0.
REQ-037 While i_rst=1, asynchronously: o_rom_addr=0, both pipeline flags=0, o_heart_on=0, o_rgb=8'h00.
REQ-038 Reset asserted mid-frame SHALL discard in-flight pipeline pixels.
REQ-039 The first valid output after reset SHALL come 3 cycles after the first post-reset pixel.

Verification
REQ-040 After reset, drive pixel (313,313) with video_on=1 -> o_rom_addr=0 after 1 cycle; with i_rom_data=8'hE0, o_heart_on=1 and o_rgb=8'hE0 after 3 cycles.
REQ-041 Drive pixels (327,327), (328,327) and (327,313) with video_on=0 -> o_rom_addr=224 with heart_on=1 for the first; heart_on=0 for the second and third.
REQ-042 Hold i_right for 200 frame ticks -> o_heart_x=406, then stays; hold i_up -> o_heart_y=240; hold left+right together -> o_heart_x unchanged.
REQ-043 Send an i_hit pulse, then a second hit 10 frames later -> o_invuln=1 for exactly 60 frame ticks; the second hit is ignored; during in-region pixels, heart_on is gated off whenever count[2]=0.
REQ-044 Drive an in-region pixel with i_rom_data=8'h00 -> o_heart_on=0, o_rgb=8'h00.
REQ-045 Assert i_rst mid-frame with the heart at (400,300) -> outputs 0 immediately; position returns to (313,313) and counter to 0.
